// File: rtl/pattern_detect_param_if.sv
// pattern_detect_param_if
//   Bundles the button inputs and all recogniser status outputs of
//   pattern_detect_param so the design and its environment share one port.
//   master: environment side (drives button, observes status)
//   slave : recogniser side (reads button, drives status)
//   Signals:
//     button      raw active-high push-buttons
//     sym_valid   1-cycle pulse, a symbol was accepted
//     sym         last accepted symbol (held)
//     multi_err   1-cycle pulse, ambiguous press rejected
//     match       1-cycle pulse, history equals the pattern
//     LED         [0] stretched match, [1] armed
//     prsnt_state number of symbols currently held
//     match_cnt   saturating match total
interface pattern_detect_param_if #(
  parameter int NUM_BTN = 2,
  parameter int SYM_W   = 1,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_BTN-1:0]               button;
  logic                             sym_valid;
  logic [SYM_W-1:0]                 sym;
  logic                             multi_err;
  logic                             match;
  logic [1:0]                       LED;
  logic [$clog2(PAT_LEN+1)-1:0]     prsnt_state;
  logic [CNT_W-1:0]                 match_cnt;

  modport master (
    output button,
    input  sym_valid, sym, multi_err, match, LED, prsnt_state, match_cnt
  );

  modport slave (
    input  button,
    output sym_valid, sym, multi_err, match, LED, prsnt_state, match_cnt
  );
endinterface

// File: rtl/pattern_detect_param.sv
// pattern_detect_param
//   Button-driven sequence recogniser. Raw buttons are synchronised and
//   debounced on a slow sample tick; each clean single press becomes one
//   symbol (the button index). The newest PAT_LEN symbols are compared with
//   PATTERN (oldest symbol in the MS position), in overlapping or
//   non-overlapping mode.
//   Ports:
//     clk    system clock
//     clr_n  asynchronous active-low reset, clears every flop
//     bus    pattern_detect_param_if.slave (button in, status out)
module pattern_detect_param #(
  parameter int                         NUM_BTN     = 2,
  parameter int                         SYM_W       = 1,
  parameter int                         PAT_LEN     = 4,
  parameter logic [PAT_LEN*SYM_W-1:0]   PATTERN     = 4'b1011,
  parameter bit                         OVERLAP     = 1'b1,
  parameter int                         DIV_BITS    = 18,
  parameter int                         DEB_SAMPLES = 4,
  parameter int                         CNT_W       = 8
) (
  input logic                   clk,
  input logic                   clr_n,
  pattern_detect_param_if.slave bus
);

  localparam int HIST_W = PAT_LEN * SYM_W;
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int DEB_W  = $clog2(DEB_SAMPLES);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

  logic [NUM_BTN-1:0]   sync_meta, sync_btn;
  logic [DIV_BITS-1:0]  div_cnt;
  logic                 tick;
  logic [NUM_BTN-1:0]   deb_level, seen_low, flip, rise;
  logic [DEB_W-1:0]     deb_cnt [NUM_BTN];
  logic                 one_rise;
  logic [SYM_W-1:0]     rise_idx;
  logic                 sym_valid_q, multi_err_q, match_q;
  logic [SYM_W-1:0]     sym_q;
  // Only the PAT_LEN-1 older symbols are stored; the newest comes from sym_q.
  logic [HIST_W-SYM_W-1:0] history;
  logic [HIST_W-1:0]    hist_shift;
  logic [FILL_W-1:0]    fill, fill_inc;
  logic                 hit;
  state_t               state;
  logic [CNT_W-1:0]     match_cnt_q;
  logic                 led_match;
  logic [4:0]           led_hold;

  // Two-flop synchroniser per button
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_meta <= '0;
      sync_btn  <= '0;
    end else begin
      sync_meta <= bus.button;
      sync_btn  <= sync_meta;
    end
  end

  // Free-running divider; tick is high for the one cycle in which the counter reads 0
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_cnt + DIV_BITS'(1);
      tick    <= &div_cnt;
    end
  end

  // A level flips on the DEB_SAMPLES-th consecutive disagreeing sample.
  // A rise only counts once the button has been seen low since reset,
  // so a button held through reset never produces a symbol.
  always_comb begin
    flip = '0;
    rise = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      flip[i] = tick && (sync_btn[i] != deb_level[i]) && (deb_cnt[i] == DEB_LAST);
      rise[i] = flip[i] && !deb_level[i] && seen_low[i];
    end
  end

  // Per-button debounce counters and levels, advanced only on sample ticks
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      deb_level <= '0;
      seen_low  <= '0;
      for (int i = 0; i < NUM_BTN; i++) deb_cnt[i] <= '0;
    end else begin
      deb_level <= deb_level ^ flip;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (tick) begin
          if (sync_btn[i] == deb_level[i] || flip[i]) deb_cnt[i] <= '0;
          else deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          if (!sync_btn[i]) seen_low[i] <= 1'b1;
        end
      end
    end
  end

  // Identify the rising button and whether it rose alone
  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rise[i]) rise_idx = SYM_W'(i);
    end
    one_rise = (rise != '0) && ((rise & (rise - NUM_BTN'(1))) == '0);
  end

  // A lone rise with every other button released is a symbol; anything else is an error
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sym_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      sym_q       <= '0;
    end else begin
      sym_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      if (rise != '0) begin
        if (one_rise && deb_level == '0) begin
          sym_valid_q <= 1'b1;
          sym_q       <= rise_idx;
        end else begin
          multi_err_q <= 1'b1;
        end
      end
    end
  end

  // Next history/fill as they will be after accepting the current symbol
  always_comb begin
    hist_shift = {history, sym_q};
    fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit        = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);
  end

  // Matcher FSM: FILL until PAT_LEN symbols are held, then ARMED.
  // In non-overlap mode a match empties the fill count and drops back to FILL.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      history     <= '0;
      fill        <= '0;
      state       <= FILL;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      match_q <= 1'b0;
      if (sym_valid_q) begin
        history <= hist_shift[HIST_W-SYM_W-1:0];
        match_q <= hit;
        if (hit && !OVERLAP) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill  <= fill_inc;
          state <= (fill_inc == FILL_FULL) ? ARMED : FILL;
        end
        if (hit && match_cnt_q != '1) match_cnt_q <= match_cnt_q + CNT_W'(1);
      end
    end
  end

  // Match LED stretcher: 16 sample ticks after the latest match
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      led_match <= 1'b0;
      led_hold  <= '0;
    end else if (sym_valid_q && hit) begin
      led_match <= 1'b1;
      led_hold  <= 5'd16;
    end else if (tick && led_hold != '0) begin
      led_hold <= led_hold - 5'd1;
      if (led_hold == 5'd1) led_match <= 1'b0;
    end
  end

  assign bus.sym_valid   = sym_valid_q;
  assign bus.sym         = sym_q;
  assign bus.multi_err   = multi_err_q;
  assign bus.match       = match_q;
  assign bus.LED         = {state == ARMED, led_match};
  assign bus.prsnt_state = fill;
  assign bus.match_cnt   = match_cnt_q;

endmodule
